result_collector: RTL
=====================

RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the polarity and synchronicity are fixed.
REQ-002 Parameter BITWIDTH SHALL default to 16; it is the packed word width.
REQ-003 Parameter LATENCY SHALL default to 5; it is the number of upstream pipeline cycles discarded after start.
REQ-004 Parameter FIFO_DEPTH SHALL default to 4; it is the output FIFO entry count and SHALL be a power of 2.
REQ-005 Port clk SHALL be an input, 1 bit: the rising-edge clock.
REQ-006 Port reset SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-007 Port start SHALL be an input, 1 bit: a single-cycle capture request.
REQ-008 Port num_words SHALL be an input, 8 bits: the number of words to capture, sampled with start.
REQ-009 Port result_in SHALL be an input, 1 bit: the serial result from the upstream pipeline.
REQ-010 Port out_data SHALL be an output, BITWIDTH bits: the FIFO head word.
REQ-011 Port out_valid SHALL be an output, 1 bit: out_data is valid.
REQ-012 Port out_ready SHALL be an input, 1 bit: the consumer accepts out_data.
REQ-013 Port busy SHALL be an output, 1 bit: the FSM is not in IDLE.
REQ-014 Port done SHALL be an output, 1 bit: a one-cycle pulse at the end of a capture.
REQ-015 Port overflow SHALL be an output, 1 bit: sticky, set when a word is dropped.

Function
REQ-016 The FSM SHALL have four states: IDLE, SKIP, COLLECT, DRAIN.
REQ-017 In IDLE, start=1 with num_words!=0 SHALL latch num_words, clear overflow, and go to SKIP.
REQ-018 In IDLE, start=1 with num_words==0 SHALL pulse done on the next cycle and stay in IDLE.
REQ-019 start SHALL be ignored in any state other than IDLE.
REQ-020 SKIP SHALL last exactly LATENCY cycles and discard result_in, then go to COLLECT.
REQ-021 If start is sampled on edge N, the first collected bit SHALL be result_in sampled on edge N+LATENCY+1.
REQ-022 COLLECT SHALL sample result_in every cycle into a shift register, LSB-first: bit k of the word is the k-th sample.
REQ-023 On the cycle the BITWIDTH-th bit is sampled, the completed word SHALL be pushed to the FIFO, the bit counter wrapped to 0, and the word counter incremented.
REQ-024 When the word counter reaches the latched num_words, the FSM SHALL go to DRAIN.
REQ-025 DRAIN SHALL wait until the FIFO is empty, then go to IDLE with done=1 for that single cycle.
REQ-026 A push to a full FIFO without a same-cycle pop SHALL drop the word and set overflow.
REQ-027 A dropped word SHALL still count toward num_words.
REQ-028 A push to a full FIFO with a same-cycle pop (out_valid & out_ready) SHALL be accepted.
REQ-029 A pushed word SHALL appear on out_data/out_valid the cycle after the push when the FIFO was empty.
REQ-030 out_data and out_valid SHALL be held stable while out_valid=1 and out_ready=0.
REQ-031 A pop SHALL occur only when out_valid=1 and out_ready=1.
REQ-032 out_data SHALL be 0 whenever out_valid=0.
REQ-033 busy SHALL be 1 in SKIP, COLLECT and DRAIN.

Reset
REQ-034 Reset SHALL force the FSM to IDLE and all counters and the shift register to 0.
REQ-035 Reset SHALL empty the FIFO.
REQ-036 Reset SHALL drive out_data=0, out_valid=0, busy=0, done=0 and overflow=0.
REQ-037 Reset asserted mid-capture SHALL discard all partial and queued words; no done pulse SHALL follow.

Structure
REQ-038 Package result_collector_pkg SHALL hold the state enum typedef and the default BITWIDTH, LATENCY and FIFO_DEPTH constants.
REQ-039 The FIFO SHALL be a sub-module named sync_fifo (parameters WIDTH, DEPTH; signals push, pop, full, empty, data).
REQ-040 Total RTL size SHALL be 120-400 lines.

Verification
REQ-041 Scenario: start with num_words=2, result_in=1 always, out_ready=1 -> two words 0xFFFF, done pulses once, overflow=0.
REQ-042 Scenario: num_words=1, result_in alternating 1,0 from the first collected cycle -> word 0x5555; bits sampled during SKIP do not appear.
REQ-043 Scenario: out_ready=0, num_words=6 -> 4 words held, 2 dropped, overflow=1; raising out_ready drains 4 words, then done.
REQ-044 Scenario: FIFO full with out_ready=1 on the push cycle -> no drop, overflow stays 0.
REQ-045 Scenario: start with num_words=0 -> done the next cycle, busy stays 0, no output words.
REQ-046 Scenario: reset asserted in COLLECT after 7 bits -> all outputs 0 immediately, no words or done afterward; a new start then behaves per REQ-041.

Source files
------------

// File: rtl/result_collector_pkg.sv
// rtl/result_collector_pkg.sv - shared state encoding and default sizing for the result collector
package result_collector_pkg;

    localparam int DEF_BITWIDTH   = 16;
    localparam int DEF_LATENCY    = 5;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word-fall-through head and zeroed idle output
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign data_out  = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - deserialises a pipelined serial result stream into words queued for a consumer
module result_collector
    import result_collector_pkg::*;
#(
    parameter int BITWIDTH   = DEF_BITWIDTH,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          num_words,
    input  logic                result_in,
    output logic [BITWIDTH-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int BCW = $clog2(BITWIDTH);
    localparam int SCW = $clog2(LATENCY + 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BITWIDTH - 1);
    localparam logic [SCW-1:0] SKIP_LAST = SCW'(LATENCY - 1);

    state_t              r_state;
    state_t              w_next;
    logic [SCW-1:0]      r_skip_cnt;
    logic [BCW-1:0]      r_bit_cnt;
    logic [7:0]          r_word_cnt;
    logic [7:0]          r_num_words;
    logic [BITWIDTH-2:0] r_shift;
    logic                r_done;
    logic                r_overflow;

    logic                w_start_go;
    logic                w_done_set;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic [BITWIDTH-1:0] w_word;

    // Newest sample enters at the MSB so the first sample ends up in bit 0.
    assign w_word    = {result_in, r_shift};
    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;
    assign w_drop    = w_push & w_full & ~w_pop;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign overflow  = r_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_start_go = 1'b0;
        w_done_set = 1'b0;
        w_push     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (num_words != 8'd0) begin
                        w_start_go = 1'b1;
                        w_next     = ST_SKIP;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end
            end
            ST_SKIP: begin
                if (r_skip_cnt == SKIP_LAST) w_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (r_bit_cnt == BIT_LAST) begin
                    w_push = 1'b1;
                    if (r_word_cnt + 8'd1 == r_num_words) w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_done_set = 1'b1;
                    w_next     = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skip_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_word_cnt  <= '0;
            r_num_words <= '0;
            r_shift     <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (w_start_go) begin
                r_skip_cnt  <= '0;
                r_bit_cnt   <= '0;
                r_word_cnt  <= '0;
                r_shift     <= '0;
                r_num_words <= num_words;
                r_overflow  <= 1'b0;
            end else begin
                if (w_drop) r_overflow <= 1'b1;
                if (r_state == ST_SKIP) r_skip_cnt <= r_skip_cnt + 1'b1;
                if (r_state == ST_COLLECT) begin
                    r_shift <= w_word[BITWIDTH-1:1];
                    if (w_push) begin
                        r_bit_cnt  <= '0;
                        r_word_cnt <= r_word_cnt + 8'd1;
                    end else begin
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (BITWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (w_push),
        .data_in  (w_word),
        .pop      (w_pop),
        .data_out (out_data),
        .full     (w_full),
        .empty    (w_empty)
    );

endmodule
